// File: rtl/sa_cache.sv
// sa_cache: 2-way set-associative, one-word-line, write-through /
// no-write-allocate cache between a CPU port and a simple memory port.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   read_en, write_en           CPU request strobes (write wins if both set)
//   addr, write_data            CPU byte address / store data (held while stall=1)
//   read_data, hit              load data, valid when hit=1
//   miss                        one-cycle pulse on a read miss
//   stall                       CPU must hold its request while high
//   mem_req, mem_we             memory request (held until mem_ack), 1 = write
//   mem_addr, mem_wdata         word-aligned memory address / write data
//   mem_rdata, mem_ack          refill data, single-cycle completion
//   hit_count, miss_count       saturating event counters
//
// state  | meaning
// IDLE   | accept CPU requests; read hits complete here
// REFILL | read miss: fetch the word from memory into the victim way
// WRITE  | write-through: forward the store to memory
// DONE   | store acknowledged; release the CPU for one cycle
module sa_cache #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_en,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  hit,
   output logic                  miss,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [SETS-1:0] valid0_q, valid0_d;
   logic [SETS-1:0] valid1_q, valid1_d;
   // lru bit per set names the way to replace next
   logic [SETS-1:0] lru_q, lru_d;

   logic [TAG_W-1:0]      tag0_q  [SETS];
   logic [TAG_W-1:0]      tag0_d  [SETS];
   logic [TAG_W-1:0]      tag1_q  [SETS];
   logic [TAG_W-1:0]      tag1_d  [SETS];
   logic [DATA_WIDTH-1:0] data0_q [SETS];
   logic [DATA_WIDTH-1:0] data0_d [SETS];
   logic [DATA_WIDTH-1:0] data1_q [SETS];
   logic [DATA_WIDTH-1:0] data1_d [SETS];

   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             hit0;
   logic             hit1;
   logic             way_hit;
   logic             hit_way;
   logic             victim;

   assign idx = addr[2 +: IDX_W];
   assign tag = addr[ADDR_WIDTH-1 -: TAG_W];

   assign hit0    = valid0_q[idx] && (tag0_q[idx] == tag);
   assign hit1    = valid1_q[idx] && (tag1_q[idx] == tag);
   assign way_hit = hit0 | hit1;
   // a line is never resident in both ways, so way0 taking precedence is safe
   assign hit_way = ~hit0;

   always_comb begin
      if (!valid0_q[idx]) begin
         victim = 1'b0;
      end else if (!valid1_q[idx]) begin
         victim = 1'b1;
      end else begin
         victim = lru_q[idx];
      end
   end

   always_comb begin
      state_d   = state_q;
      valid0_d  = valid0_q;
      valid1_d  = valid1_q;
      lru_d     = lru_q;
      tag0_d    = tag0_q;
      tag1_d    = tag1_q;
      data0_d   = data0_q;
      data1_d   = data1_q;
      hit       = 1'b0;
      miss      = 1'b0;
      stall     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      read_data = '0;
      mem_wdata = '0;
      mem_addr  = addr & ~ADDR_WIDTH'(3);

      case (state_q)
         IDLE: begin
            if (write_en) begin
               stall   = 1'b1;
               state_d = WRITE;
               if (way_hit) begin
                  if (hit_way) begin
                     data1_d[idx] = write_data;
                  end else begin
                     data0_d[idx] = write_data;
                  end
                  lru_d[idx] = ~hit_way;
               end
            end else if (read_en) begin
               if (way_hit) begin
                  hit        = 1'b1;
                  read_data  = hit_way ? data1_q[idx] : data0_q[idx];
                  lru_d[idx] = ~hit_way;
               end else begin
                  miss    = 1'b1;
                  stall   = 1'b1;
                  state_d = REFILL;
               end
            end
         end

         REFILL: begin
            mem_req = 1'b1;
            stall   = 1'b1;
            if (mem_ack) begin
               if (victim) begin
                  valid1_d[idx] = 1'b1;
                  tag1_d[idx]   = tag;
                  data1_d[idx]  = mem_rdata;
               end else begin
                  valid0_d[idx] = 1'b1;
                  tag0_d[idx]   = tag;
                  data0_d[idx]  = mem_rdata;
               end
               lru_d[idx] = ~victim;
               state_d    = IDLE;
            end
         end

         WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = write_data;
            stall     = 1'b1;
            if (mem_ack) begin
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
         hit_count_d = hit_count_q + 32'd1;
      end
      if (miss && (miss_count_q != 32'hFFFF_FFFF)) begin
         miss_count_d = miss_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         valid0_q     <= '0;
         valid1_q     <= '0;
         lru_q        <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         valid0_q     <= valid0_d;
         valid1_q     <= valid1_d;
         lru_q        <= lru_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   // tag/data storage needs no reset: valid bits gate every use of it
   always_ff @(posedge clk) begin
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_sa_cache.sv
module tb_sa_cache;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SETS = 4;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          read_en    = 1'b0;
   logic          write_en   = 1'b0;
   logic [AW-1:0] addr       = '0;
   logic [DW-1:0] write_data = '0;
   logic [DW-1:0] read_data;
   logic          hit;
   logic          miss;
   logic          stall;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;

   logic          ack_resp   = 1'b0;
   logic          ack_main   = 1'b0;
   logic [DW-1:0] rdata_resp = '0;
   logic [DW-1:0] rdata_main = '0;

   assign mem_ack   = ack_resp | ack_main;
   assign mem_rdata = ack_main ? rdata_main : rdata_resp;

   always #5 clk = ~clk;

   sa_cache #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .SETS       (SETS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .read_en    (read_en),
      .write_en   (write_en),
      .addr       (addr),
      .write_data (write_data),
      .read_data  (read_data),
      .hit        (hit),
      .miss       (miss),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   typedef struct packed {
      bit          is_hit;
      logic [31:0] data;
   } ev_t;

   typedef struct packed {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } mx_t;

   ev_t exp_q[$];
   mx_t mem_q[$];

   // backing memory contents, keyed by word address
   bit [31:0] mem_model [bit [29:0]];
   // resident words, most recently used first
   bit [29:0] lines[$];

   int  checks     = 0;
   int  errors     = 0;
   int  exp_hits   = 0;
   int  exp_misses = 0;
   bit  resp_en    = 1'b1;
   bit  abort      = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void push_ev(input bit h, input logic [31:0] d);
      ev_t e;
      e.is_hit = h;
      e.data   = d;
      exp_q.push_back(e);
   endfunction

   function automatic void push_mem(input bit we, input logic [31:0] a, input logic [31:0] d);
      mx_t m;
      m.we   = we;
      m.addr = a;
      m.data = d;
      mem_q.push_back(m);
   endfunction

   function automatic int find_line(input bit [29:0] w);
      foreach (lines[i]) begin
         if (lines[i] == w) return i;
      end
      return -1;
   endfunction

   function automatic void touch(input bit [29:0] w);
      int p;
      p = find_line(w);
      if (p >= 0) lines.delete(p);
      lines.push_front(w);
   endfunction

   // two lines per set; on a full set the least recently used one leaves
   function automatic void fill(input bit [29:0] w);
      int n;
      int last;
      n    = 0;
      last = -1;
      foreach (lines[i]) begin
         if ((lines[i] % SETS) == (w % SETS)) begin
            n++;
            last = i;
         end
      end
      if (n >= 2) lines.delete(last);
      lines.push_front(w);
   endfunction

   task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
      bit [29:0]   w;
      logic [31:0] aligned;
      int          n;
      w       = a[31:2];
      aligned = {a[31:2], 2'b00};
      if (wr) begin
         push_mem(1'b1, aligned, wd);
         mem_model[w] = wd;
         if (find_line(w) >= 0) touch(w);
      end else if (rd) begin
         if (!mem_model.exists(w)) mem_model[w] = $urandom;
         if (find_line(w) >= 0) begin
            push_ev(1'b1, mem_model[w]);
            touch(w);
            exp_hits++;
         end else begin
            push_ev(1'b0, 32'h0);
            push_mem(1'b0, aligned, mem_model[w]);
            push_ev(1'b1, mem_model[w]);
            fill(w);
            exp_misses++;
            exp_hits++;
         end
      end
      @(negedge clk);
      read_en    = rd;
      write_en   = wr;
      addr       = a;
      write_data = wd;
      #2;
      n = 0;
      while (stall && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (stall) begin
         checks++;
         errors++;
         abort = 1'b1;
         $display("FAIL op_timeout: stall still 1 after 100 cycles for addr 0x%08h, expected 0", a);
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      read_en  = 1'b0;
      write_en = 1'b0;
   endtask

   task automatic check_counts(input string tag);
      go_idle();
      #2;
      check({tag, "_hit_count"}, hit_count, exp_hits);
      check({tag, "_miss_count"}, miss_count, exp_misses);
   endtask

   // memory responder: acks each request after 0..3 cycles and checks it
   initial begin : responder
      int  dly;
      mx_t m;
      dly = -1;
      forever begin
         @(negedge clk);
         ack_resp = 1'b0;
         if (resp_en && mem_req && !rst) begin
            if (dly < 0) dly = $urandom_range(0, 3);
            if (dly == 0) begin
               dly = -1;
               if (mem_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL mem_unexpected: mem_req=1 addr=0x%08h we=%0b, no request expected", mem_addr, mem_we);
                  rdata_resp = '0;
               end else begin
                  m = mem_q.pop_front();
                  check("mem_we", 32'(mem_we), 32'(m.we));
                  check("mem_addr", mem_addr, m.addr);
                  if (m.we) check("mem_wdata", mem_wdata, m.data);
                  rdata_resp = m.data;
               end
               ack_resp = 1'b1;
            end else begin
               dly--;
            end
         end
      end
   end

   // response monitor: every hit/miss pulse is matched against the queue
   initial begin : monitor
      ev_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && (hit || miss)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_response: hit=%0b miss=%0b addr=0x%08h, none expected", hit, miss, addr);
            end else begin
               e = exp_q.pop_front();
               check("resp_hit", 32'(hit), 32'(e.is_hit));
               check("resp_miss", 32'(miss), 32'(!e.is_hit));
               if (e.is_hit) begin
                  check("read_data", read_data, e.data);
                  check("stall_on_hit", 32'(stall), 32'd0);
               end else begin
                  check("stall_on_miss", 32'(stall), 32'd1);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin : main
      int          n;
      int          r;
      logic [31:0] a;

      repeat (2) @(negedge clk);
      #2;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_miss", 32'(miss), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_hit_count", hit_count, 32'd0);
      check("rst_miss_count", miss_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("idle_stall", 32'(stall), 32'd0);

      // first miss then hit on the refilled word
      mem_model[30'h40] = 32'hDEAD_BEEF;
      do_op(1'b1, 1'b0, 32'h100, 32'h0);
      check_counts("first");
      check("first_miss_const", miss_count, 32'd1);
      check("first_hit_const", hit_count, 32'd1);

      // LRU replacement within set 0
      do_op(1'b1, 1'b0, 32'h200, 32'h0);
      do_op(1'b1, 1'b0, 32'h100, 32'h0);
      do_op(1'b1, 1'b0, 32'h300, 32'h0);
      do_op(1'b1, 1'b0, 32'h100, 32'h0);
      do_op(1'b1, 1'b0, 32'h200, 32'h0);
      check_counts("lru");

      // write hit, uncached write, write priority over read
      do_op(1'b0, 1'b1, 32'h100, 32'h55);
      do_op(1'b1, 1'b0, 32'h100, 32'h0);
      do_op(1'b0, 1'b1, 32'h400, 32'h1234_5678);
      do_op(1'b1, 1'b0, 32'h400, 32'h0);
      do_op(1'b1, 1'b1, 32'h100, 32'hA5A5_A5A5);
      do_op(1'b1, 1'b0, 32'h100, 32'h0);
      check_counts("write");

      // reset during refill with a simultaneous ack
      resp_en = 1'b0;
      push_ev(1'b0, 32'h0);
      @(negedge clk);
      read_en  = 1'b1;
      write_en = 1'b0;
      addr     = 32'h500;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_req && n < 10);
      check("refill_mem_req", 32'(mem_req), 32'd1);
      check("refill_mem_we", 32'(mem_we), 32'd0);
      rst        = 1'b1;
      read_en    = 1'b0;
      ack_main   = 1'b1;
      rdata_main = 32'h1234_5678;
      #2;
      check("rst_async_mem_req", 32'(mem_req), 32'd0);
      check("rst_async_mem_we", 32'(mem_we), 32'd0);
      check("rst_async_stall", 32'(stall), 32'd0);
      @(negedge clk);
      ack_main = 1'b0;
      rst      = 1'b0;
      resp_en  = 1'b1;
      lines.delete();
      exp_hits   = 0;
      exp_misses = 0;
      check_counts("after_rst");
      do_op(1'b1, 1'b0, 32'h100, 32'h0);
      do_op(1'b1, 1'b0, 32'h500, 32'h0);
      check_counts("rst_reread");

      // randomized traffic over a small address pool to force conflicts
      for (int i = 0; i < 400 && !abort; i++) begin
         a = (32'($urandom_range(0, 5)) << 4) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = a | 32'h8000_0000;
         r = $urandom_range(0, 99);
         if (r < 55) begin
            do_op(1'b1, 1'b0, a, 32'h0);
         end else if (r < 80) begin
            do_op(1'b0, 1'b1, a, $urandom);
         end else if (r < 90) begin
            do_op(1'b1, 1'b1, a, $urandom);
         end else begin
            repeat ($urandom_range(1, 2)) go_idle();
         end
      end
      check_counts("random");

      repeat (3) go_idle();
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check("mem_q_empty", 32'(mem_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sa_cache.md
SA_CACHE -- requirements
Module: sa_cache

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data word width.
- SETS, 4, number of sets; power of two, at least 2.
REQ-002 clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 rst, input, 1: reset, asynchronous and active-high.
REQ-004 read_en, input, 1: CPU read request.
REQ-005 write_en, input, 1: CPU write request.
REQ-006 addr, input, ADDR_WIDTH: CPU byte address; bits [1:0] ignored.
REQ-007 write_data, input, DATA_WIDTH: CPU store data.
REQ-008 read_data, output, DATA_WIDTH: load data, valid when hit=1.
REQ-009 hit, output, 1: request completed from the cache this cycle.
REQ-010 miss, output, 1: one-cycle pulse when a read misses.
REQ-011 stall, output, 1: CPU SHALL hold its request and operands while stall=1.
REQ-012 mem_req, output, 1: memory request, held high until mem_ack.
REQ-013 mem_we, output, 1: 1 = memory write, 0 = memory line read.
REQ-014 mem_addr, output, ADDR_WIDTH: word-aligned memory address.
REQ-015 mem_wdata, output, DATA_WIDTH: memory write data.
REQ-016 mem_rdata, input, DATA_WIDTH: refill data, valid with mem_ack.
REQ-017 mem_ack, input, 1: single-cycle completion of a memory request.
REQ-018 hit_count, output, 32: count of hit responses; saturates at 0xFFFFFFFF.
REQ-019 miss_count, output, 32: count of miss pulses; saturates at 0xFFFFFFFF.

Function
REQ-020 The cache SHALL be 2-way set-associative with one-word lines; each way holds valid, tag and data per set.
- index = addr[2 +: log2(SETS)]
- tag = addr[ADDR_WIDTH-1 : 2+log2(SETS)]
REQ-021 The FSM SHALL have states IDLE, REFILL, WRITE and DONE; requests are accepted only in IDLE.
REQ-022 Read hit in IDLE: in the same cycle, hit=1, stall=0, read_data = matching way's data; the set's LRU bit SHALL point to the other way after the edge.
REQ-023 Read miss in IDLE: miss=1 and stall=1 that cycle; the next state SHALL be REFILL.
REQ-024 In REFILL:
- mem_req=1, mem_we=0, mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}, stall=1.
- On mem_ack, write mem_rdata, the tag and valid=1 into the victim way, update LRU, and go to IDLE.
- The held read then hits in the following cycle.
REQ-025 Victim selection SHALL be: invalid way0, else invalid way1, else the way indicated by LRU.
REQ-026 Write in IDLE (write-through, no-write-allocate):
- stall=1 that cycle.
- On a tag match, the matching way's data SHALL be updated at the edge and LRU updated; on a mismatch, the array is unchanged.
- The next state SHALL be WRITE.
REQ-027 In WRITE:
- mem_req=1, mem_we=1, mem_addr word-aligned, mem_wdata = write_data, stall=1.
- On mem_ack the next state SHALL be DONE.
REQ-028 In DONE: stall=0, hit=0, miss=0; the held write completes this cycle; the next state is IDLE.
REQ-029 If read_en and write_en are both 1, the write SHALL take priority and the read is ignored.
REQ-030 With neither enable set, stall, hit and miss SHALL be 0 and no state SHALL change.
REQ-031 mem_ack outside REFILL or WRITE SHALL be ignored.
REQ-032 Counters:
- hit_count increments on every cycle with hit=1.
- miss_count increments on every cycle with miss=1.
- Neither wraps.

Reset
REQ-033 On rst the following SHALL clear immediately, independent of clk: all valid bits, all LRU bits (point to way0), both counters, FSM to IDLE, mem_req=0, mem_we=0.
REQ-034 Reset asserted during REFILL or WRITE SHALL abandon the memory transaction; no array write from a late mem_ack.
REQ-035 Reset SHALL NOT be required to clear data or tag storage.

Verification
REQ-036 After reset, read 0x100 -> miss=1; REFILL; mem_ack with 0xDEADBEEF; next cycle hit=1, read_data=0xDEADBEEF; miss_count=1, hit_count=1.
REQ-037 Fill 0x100 and 0x200 (same index, SETS=4); read 0x100; read miss 0x300 -> 0x200's way replaced; read 0x100 -> hit; read 0x200 -> miss.
REQ-038 Write 0x55 to cached 0x100 -> mem_req with mem_we=1 and mem_wdata=0x55 until ack; DONE cycle stall=0; read 0x100 -> hit with 0x55.
REQ-039 Write to uncached 0x400 -> memory write only; subsequent read 0x400 -> miss.
REQ-040 Assert rst while in REFILL with mem_ack arriving the same cycle -> FSM IDLE, mem_req=0, read 0x100 -> miss.
REQ-041 read_en and write_en both 1 to 0x100 -> write path only (mem_we=1), miss=0.
